addacc_pipe: RTL and testbench

- Parametrised, pipelined signed N-input adder tree with multi-beat accumulation and an output stage that applies scaling, rounding, saturation and optional ReLU.
- Successor to the fixed 32-input 9-bit adder used by the affine datapath.
- Sits between input-memory read lanes and output-memory write ports.
- One group = 1..MAXBEAT beats of NIN lanes; the block emits one scaled result per group.

---
 rtl/addacc_pkg.sv | 26 ++
 rtl/addacc_pipe_if.sv | 29 ++
 rtl/addacc_scale.sv | 47 ++++
 rtl/addacc_pipe.sv | 170 +++++++++++++++++
 tb/tb_addacc_pipe.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/addacc_pkg.sv
// Shared encodings, sideband record and elaboration helpers for the addacc_pipe datapath.
package addacc_pkg;

    localparam logic [1:0] MODE_TRUNC = 2'd0;
    localparam logic [1:0] MODE_SAT   = 2'd1;
    localparam logic [1:0] MODE_RELU  = 2'd2;

    // Per-beat control that travels alongside the adder tree.
    typedef struct packed {
        logic       valid;
        logic       first;
        logic       last;
        logic [1:0] mode;
        logic [3:0] shift;
    } side_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) res = unsigned'(i) + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/addacc_pipe_if.sv
// Beat input / result output bundle of addacc_pipe; master drives beats, slave is the datapath.
interface addacc_pipe_if #(
    parameter int unsigned IN_W  = 9,
    parameter int unsigned NIN   = 32,
    parameter int unsigned OUT_W = 9,
    parameter int unsigned ACC_W = 17
);
    logic                  in_valid;
    logic                  in_first;
    logic                  in_last;
    logic [NIN*IN_W-1:0]   in_data;
    logic [1:0]            mode;
    logic [3:0]            shift;
    logic                  out_valid;
    logic [OUT_W-1:0]      out_data;
    logic [ACC_W-1:0]      out_sum;
    logic                  out_ovf;
    logic                  busy;

    modport master (
        output in_valid, in_first, in_last, in_data, mode, shift,
        input  out_valid, out_data, out_sum, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_first, in_last, in_data, mode, shift,
        output out_valid, out_data, out_sum, out_ovf, busy
    );
endinterface

// File: rtl/addacc_scale.sv
// Combinational output scaling: round-half-up arithmetic shift, then truncate, clamp or ReLU-clamp.
module addacc_scale
    import addacc_pkg::*;
#(
    parameter int unsigned ACC_W = 17,
    parameter int unsigned OUT_W = 9
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [3:0]       shift_i,
    input  logic [1:0]       mode_i,
    output logic [OUT_W-1:0] data_o
);
    // One extra bit so the rounding add can never wrap.
    localparam int unsigned RW = ACC_W + 1;
    localparam logic signed [RW-1:0] MaxV = {{(RW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [RW-1:0] MinV = ~MaxV;

    logic signed [RW-1:0] ext;
    logic signed [RW-1:0] half;
    logic signed [RW-1:0] r;

    always_comb begin
        ext  = $signed({acc_i[ACC_W-1], acc_i});
        half = '0;
        r    = ext;
        if (shift_i != 4'd0) begin
            half = {{(RW - 1){1'b0}}, 1'b1} << (shift_i - 4'd1);
            r    = (ext + half) >>> shift_i;
        end
    end

    always_comb begin
        data_o = r[OUT_W-1:0];
        case (mode_i)
            MODE_TRUNC: data_o = r[OUT_W-1:0];
            MODE_RELU: begin
                if (r[RW-1])      data_o = '0;
                else if (r > MaxV) data_o = MaxV[OUT_W-1:0];
            end
            default: begin
                if (r > MaxV)      data_o = MaxV[OUT_W-1:0];
                else if (r < MinV) data_o = MinV[OUT_W-1:0];
            end
        endcase
    end

endmodule

// File: rtl/addacc_pipe.sv
// Pipelined signed NIN-lane adder tree with multi-beat group accumulation and a scaled output stage.
module addacc_pipe
    import addacc_pkg::*;
#(
    parameter int unsigned IN_W    = 9,
    parameter int unsigned NIN     = 32,
    parameter int unsigned MAXBEAT = 8,
    parameter int unsigned OUT_W   = 9
) (
    input logic         clock,
    input logic         reset,
    addacc_pipe_if.slave io
);
    localparam int unsigned LOG2N = clog2(NIN);
    localparam int unsigned ACC_W = IN_W + LOG2N + clog2(MAXBEAT);
    localparam int unsigned CNT_W = clog2(MAXBEAT) + 2;
    localparam int unsigned NNODE = NIN - 1;
    localparam logic [CNT_W-1:0] CntSat = CNT_W'(MAXBEAT + 1);

    // Tree held as a heap: node j sums children 2j+1 / 2j+2, leaves follow the internal nodes.
    // All leaves sit at the same depth, so each heap level is exactly one register stage.
    logic [ACC_W-1:0] leaf   [NIN];
    logic [ACC_W-1:0] node_d [NNODE];
    logic [ACC_W-1:0] node_q [NNODE];

    for (genvar k = 0; k < NIN; k++) begin : g_leaf
        assign leaf[k] = {{(ACC_W - IN_W){io.in_data[k*IN_W + IN_W - 1]}},
                          io.in_data[k*IN_W +: IN_W]};
    end

    for (genvar j = 0; j < NNODE; j++) begin : g_node
        if (2 * j + 1 < NNODE) begin : g_inner
            assign node_d[j] = node_q[2*j+1] + node_q[2*j+2];
        end else begin : g_edge
            assign node_d[j] = leaf[2*j+1-NNODE] + leaf[2*j+2-NNODE];
        end
    end

    side_t side_d [LOG2N];
    side_t side_q [LOG2N];

    always_comb begin
        side_d[0].valid = io.in_valid;
        side_d[0].first = io.in_valid & io.in_first;
        side_d[0].last  = io.in_valid & io.in_last;
        side_d[0].mode  = io.mode;
        side_d[0].shift = io.shift;
        for (int unsigned i = 1; i < LOG2N; i++) side_d[i] = side_q[i-1];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned j = 0; j < NNODE; j++) node_q[j] <= '0;
            for (int unsigned i = 0; i < LOG2N; i++) side_q[i] <= '0;
        end else begin
            for (int unsigned j = 0; j < NNODE; j++) node_q[j] <= node_d[j];
            for (int unsigned i = 0; i < LOG2N; i++) side_q[i] <= side_d[i];
        end
    end

    // Accumulate stage.
    side_t            tail;
    logic [ACC_W-1:0] acc_d, acc_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             open_d, open_q;
    logic             fin_d, fin_q;
    logic [1:0]       mode_d, mode_q;
    logic [3:0]       shift_d, shift_q;

    assign tail = side_q[LOG2N-1];

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        open_d  = open_q;
        fin_d   = 1'b0;
        mode_d  = mode_q;
        shift_d = shift_q;
        if (tail.valid) begin
            // A stray beat with no open group, or a new first, restarts the group.
            if (tail.first || !open_q) begin
                acc_d = node_q[0];
                cnt_d = CNT_W'(1);
            end else begin
                acc_d = acc_q + node_q[0];
                if (cnt_q != CntSat) cnt_d = cnt_q + CNT_W'(1);
            end
            open_d = !tail.last;
            fin_d  = tail.last;
            if (tail.last) begin
                mode_d  = tail.mode;
                shift_d = tail.shift;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            open_q  <= 1'b0;
            fin_q   <= 1'b0;
            mode_q  <= '0;
            shift_q <= '0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            open_q  <= open_d;
            fin_q   <= fin_d;
            mode_q  <= mode_d;
            shift_q <= shift_d;
        end
    end

    // Output stage.
    logic [OUT_W-1:0] scaled;
    logic             out_valid_d, out_valid_q;
    logic [OUT_W-1:0] out_data_d, out_data_q;
    logic [ACC_W-1:0] out_sum_d, out_sum_q;
    logic             out_ovf_d, out_ovf_q;
    logic             busy;

    addacc_scale #(
        .ACC_W(ACC_W),
        .OUT_W(OUT_W)
    ) u_scale (
        .acc_i  (acc_q),
        .shift_i(shift_q),
        .mode_i (mode_q),
        .data_o (scaled)
    );

    always_comb begin
        out_valid_d = fin_q;
        out_data_d  = out_data_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        if (fin_q) begin
            out_data_d = scaled;
            out_sum_d  = acc_q;
            out_ovf_d  = (cnt_q > CNT_W'(MAXBEAT));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    always_comb begin
        busy = open_q | fin_q | out_valid_q;
        for (int unsigned i = 0; i < LOG2N; i++) busy = busy | side_q[i].valid;
    end

    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_sum   = out_sum_q;
    assign io.out_ovf   = out_ovf_q;
    assign io.busy      = busy;

endmodule

// File: tb/tb_addacc_pipe.sv
// Directed plus randomized check of addacc_pipe against a group-level arithmetic reference model.
module tb_addacc_pipe;
    import addacc_pkg::*;

    localparam int unsigned IN_W    = 9;
    localparam int unsigned NIN     = 32;
    localparam int unsigned MAXBEAT = 8;
    localparam int unsigned OUT_W   = 9;
    localparam int unsigned LOG2N   = clog2(NIN);
    localparam int unsigned ACC_W   = IN_W + LOG2N + clog2(MAXBEAT);
    localparam int LN = int'(LOG2N);

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    addacc_pipe_if #(.IN_W(IN_W), .NIN(NIN), .OUT_W(OUT_W), .ACC_W(ACC_W)) bus ();

    addacc_pipe #(
        .IN_W   (IN_W),
        .NIN    (NIN),
        .MAXBEAT(MAXBEAT),
        .OUT_W  (OUT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io   (bus)
    );

    typedef struct {
        int     due;
        longint data;
        longint sum;
        bit     ovf;
    } exp_t;

    exp_t   exp_q[$];
    int     tests = 0;
    int     fails = 0;
    int     edge_n = 0;
    int     rst_edge = 0;
    bit     beat_at [8192];
    bit     open_at [8192];
    bit     m_open = 0;
    longint m_sum = 0;
    int     m_cnt = 0;
    longint hold_data = 0;
    longint hold_sum = 0;
    bit     hold_ovf = 0;
    logic [IN_W-1:0] lane_v [NIN];

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Reference: wrap to ACC_W, round-half-up shift, then apply the selected output mode.
    function automatic longint wrap_acc(input longint s);
        longint a;
        a = s & ((longint'(1) << ACC_W) - 1);
        if (a >= (longint'(1) << (ACC_W - 1))) a -= (longint'(1) << ACC_W);
        return a;
    endfunction

    function automatic longint scale_ref(input longint a, input int sh, input int md);
        longint r, mx, mn;
        mx = (longint'(1) << (OUT_W - 1)) - 1;
        mn = -mx - 1;
        r  = (sh > 0) ? ((a + (longint'(1) << (sh - 1))) >>> sh) : a;
        if (md == 0) begin
            r = r & ((longint'(1) << OUT_W) - 1);
            if (r > mx) r -= (longint'(1) << OUT_W);
        end else if (md == 2) begin
            if (r < 0) r = 0;
            else if (r > mx) r = mx;
        end else begin
            if (r > mx) r = mx;
            else if (r < mn) r = mn;
        end
        return r;
    endfunction

    task automatic model_beat();
        longint t = 0;
        exp_t   e;
        for (int k = 0; k < int'(NIN); k++) t += longint'($signed(bus.in_data[k*IN_W +: IN_W]));
        if (bus.in_first || !m_open) begin
            m_sum = t;
            m_cnt = 1;
        end else begin
            m_sum += t;
            m_cnt++;
        end
        if (bus.in_last) begin
            e.due  = edge_n + LN + 1;
            e.sum  = wrap_acc(m_sum);
            e.data = scale_ref(e.sum, int'(bus.shift), int'(bus.mode));
            e.ovf  = (m_cnt > int'(MAXBEAT));
            exp_q.push_back(e);
            m_open = 0;
        end else begin
            m_open = 1;
        end
    endtask

    task automatic check_cycle();
        exp_t e;
        bit   exp_busy = 0;
        if (exp_q.size() != 0 && exp_q[0].due == edge_n) begin
            e = exp_q.pop_front();
            chk("out_valid", 64'(bus.out_valid), 1);
            chk("out_data", $signed(bus.out_data), e.data);
            chk("out_sum", $signed(bus.out_sum), e.sum);
            chk("out_ovf", 64'(bus.out_ovf), 64'(e.ovf));
            hold_data = e.data;
            hold_sum  = e.sum;
            hold_ovf  = e.ovf;
        end else begin
            chk("out_valid_quiet", 64'(bus.out_valid), 0);
            chk("out_data_hold", $signed(bus.out_data), hold_data);
            chk("out_sum_hold", $signed(bus.out_sum), hold_sum);
            chk("out_ovf_hold", 64'(bus.out_ovf), 64'(hold_ovf));
        end
        for (int k = 0; k <= LN + 1; k++)
            if (edge_n - k > rst_edge && beat_at[edge_n-k]) exp_busy = 1;
        if (edge_n - LN > rst_edge && open_at[edge_n-LN]) exp_busy = 1;
        chk("busy", 64'(bus.busy), 64'(exp_busy));
    endtask

    task automatic step();
        @(posedge clock);
        edge_n++;
        if (edge_n >= 8190) begin
            fails++;
            $display("FAIL cycle_budget: edge %0d, limit 8190", edge_n);
            $fatal(1, "cycle budget exhausted");
        end
        beat_at[edge_n] = bus.in_valid;
        if (bus.in_valid) model_beat();
        open_at[edge_n] = m_open;
        #1;
        check_cycle();
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic set_beat(input bit f, input bit l, input logic [1:0] m, input logic [3:0] s);
        bus.in_valid = 1'b1;
        bus.in_first = f;
        bus.in_last  = l;
        bus.mode     = m;
        bus.shift    = s;
        for (int k = 0; k < int'(NIN); k++) bus.in_data[k*IN_W +: IN_W] = lane_v[k];
    endtask

    task automatic fill(input int v);
        for (int k = 0; k < int'(NIN); k++) lane_v[k] = IN_W'(v);
    endtask

    task automatic drain();
        idle();
        repeat (LN + 3) step();
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_out_data", $signed(bus.out_data), 0);
        chk("rst_out_sum", $signed(bus.out_sum), 0);
        chk("rst_out_ovf", 64'(bus.out_ovf), 0);
        exp_q.delete();
        m_open    = 0;
        hold_data = 0;
        hold_sum  = 0;
        hold_ovf  = 0;
        @(posedge clock);
        edge_n++;
        beat_at[edge_n] = 0;
        open_at[edge_n] = 0;
        rst_edge = edge_n;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.in_data = '0;
        bus.mode    = '0;
        bus.shift   = '0;
        idle();
        #3;
        do_reset();

        // Single beat of +1 lanes.
        fill(1);
        set_beat(1, 1, MODE_TRUNC, 4'd0);
        step();
        drain();
        chk("s1_sum", $signed(bus.out_sum), 32);
        chk("s1_data", $signed(bus.out_data), 32);
        chk("s1_ovf", 64'(bus.out_ovf), 0);

        // Most negative lanes, saturate then ReLU.
        fill(-256);
        set_beat(1, 1, MODE_SAT, 4'd0);
        step();
        drain();
        chk("s2_sum", $signed(bus.out_sum), -8192);
        chk("s2_sat", $signed(bus.out_data), -256);
        set_beat(1, 1, MODE_RELU, 4'd0);
        step();
        drain();
        chk("s2_relu", $signed(bus.out_data), 0);

        // Four beats of 255 then a back-to-back ramp group; mode/shift only matter on last.
        fill(255);
        set_beat(1, 0, MODE_TRUNC, 4'd0);
        step();
        set_beat(0, 0, MODE_RELU, 4'd3);
        step();
        set_beat(0, 0, MODE_TRUNC, 4'd15);
        step();
        set_beat(0, 1, MODE_SAT, 4'd7);
        step();
        for (int k = 0; k < int'(NIN); k++) lane_v[k] = IN_W'(k);
        set_beat(1, 1, MODE_SAT, 4'd7);
        step();
        idle();
        repeat (LN) step();
        chk("s3a_sum", $signed(bus.out_sum), 32640);
        chk("s3a_data", $signed(bus.out_data), 255);
        step();
        chk("s3b_sum", $signed(bus.out_sum), 496);
        chk("s3b_data", $signed(bus.out_data), 4);

        // Round-half-up on positive and negative halves.
        fill(0);
        lane_v[0] = IN_W'(3);
        set_beat(1, 1, MODE_TRUNC, 4'd1);
        step();
        drain();
        chk("rnd_pos", $signed(bus.out_data), 2);
        lane_v[0] = IN_W'(-3);
        set_beat(1, 1, MODE_TRUNC, 4'd1);
        step();
        drain();
        chk("rnd_neg", $signed(bus.out_data), -1);

        // Nine-beat group overflows the beat budget; the next group is clean.
        fill(1);
        for (int b = 0; b < 9; b++) begin
            set_beat(b == 0, b == 8, MODE_TRUNC, 4'd0);
            step();
        end
        fill(1);
        set_beat(1, 1, MODE_TRUNC, 4'd0);
        step();
        idle();
        repeat (LN) step();
        chk("ovf_sum", $signed(bus.out_sum), 288);
        chk("ovf_set", 64'(bus.out_ovf), 1);
        step();
        chk("ovf_clear", 64'(bus.out_ovf), 0);

        // Reset during beat 2 of a four-beat group discards everything in flight.
        fill(7);
        set_beat(1, 0, MODE_SAT, 4'd0);
        step();
        set_beat(0, 0, MODE_SAT, 4'd0);
        do_reset();
        repeat (LN + 5) step();
        fill(1);
        set_beat(1, 1, MODE_TRUNC, 4'd0);
        step();
        drain();
        chk("post_rst_sum", $signed(bus.out_sum), 32);
        chk("post_rst_data", $signed(bus.out_data), 32);

        // Random groups: gaps, abandoned groups, stray beats, oversize groups, all modes.
        for (int g = 0; g < 40; g++) begin
            int nb;
            bit abandon;
            nb      = int'($urandom_range(1, 10));
            abandon = ($urandom_range(0, 7) == 0);
            for (int b = 0; b < nb; b++) begin
                for (int k = 0; k < int'(NIN); k++) lane_v[k] = IN_W'($urandom_range(0, 511));
                set_beat((b == 0) && ($urandom_range(0, 3) != 0), (b == nb - 1) && !abandon,
                         2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
                step();
                if ($urandom_range(0, 3) == 0) begin
                    idle();
                    repeat ($urandom_range(1, 3)) step();
                end
            end
            if ($urandom_range(0, 1) == 0) begin
                idle();
                step();
            end
        end
        drain();
        chk("queue_empty", 64'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
